// File: rtl/llander_pkg.sv
// Shared types and constants for the Lunar Lander thrust-lever path.
package llander_pkg;

    typedef enum logic [1:0] {
        ANALOG  = 2'd0,
        DPAD    = 2'd1,
        HANDOFF = 2'd2
    } thrust_state_t;

    localparam logic [7:0] THRUST_MAX = 8'd254;

    // Mode encodings; any value at or above TMODE_AUTO selects auto arbitration.
    localparam logic [1:0] TMODE_ANALOG = 2'd0;
    localparam logic [1:0] TMODE_DPAD   = 2'd1;
    localparam logic [1:0] TMODE_AUTO   = 2'd2;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one cycle every DIV cycles, clr restarts the count.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk_50,
    input  logic RESET_L,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    // Advance the count, wrapping after the terminal value or restarting on clr.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/thrust_input_ctrl.sv
// Thrust-lever source controller: arbitrates analog stick vs D-pad ramp with a
// rate-limited handoff so the lever value never jumps.
module thrust_input_ctrl
    import llander_pkg::*;
#(
    parameter int TICK_DIV    = 196850,
    parameter int HANDOFF_DIV = 19685,
    parameter int DEADZONE    = 16,
    parameter int MAX_THRUST  = int'(THRUST_MAX)
) (
    input  logic       clk_50,
    input  logic       RESET_L,
    input  logic [1:0] mode,
    input  logic [7:0] analog_y,
    input  logic       dpad_up,
    input  logic       dpad_down,
    output logic [7:0] thrust,
    output logic       src_dpad,
    output logic       handoff,
    output logic       at_limit
);

    localparam logic [7:0] MAX_T = MAX_THRUST[7:0];

    thrust_state_t state_q, state_d;
    logic [7:0]    thrust_q, thrust_d;
    logic [7:0]    acc_q, acc_d;
    logic          src_dpad_q, handoff_q, at_limit_q;

    logic          rtick, htick, hclr;
    logic [7:0]    ana_raw, ana;
    logic [8:0]    y_ext, abs_y;
    logic          force_ana, force_dpad, auto_mode, any_btn, stick_claim;

    tick_prescaler #(.DIV(TICK_DIV)) u_ramp_tick (
        .clk_50  (clk_50),
        .RESET_L (RESET_L),
        .clr     (1'b0),
        .tick    (rtick)
    );

    tick_prescaler #(.DIV(HANDOFF_DIV)) u_handoff_tick (
        .clk_50  (clk_50),
        .RESET_L (RESET_L),
        .clr     (hclr),
        .tick    (htick)
    );

    // Analog target (127 - y is always 0..255, so 8-bit wraparound is exact), stick magnitude, mode decode.
    always_comb begin
        ana_raw     = 8'd127 - analog_y;
        ana         = (ana_raw > MAX_T) ? MAX_T : ana_raw;
        y_ext       = {analog_y[7], analog_y};
        abs_y       = analog_y[7] ? (9'd0 - y_ext) : y_ext;
        stick_claim = (int'(abs_y) > DEADZONE);
        force_ana   = (mode == TMODE_ANALOG);
        force_dpad  = (mode == TMODE_DPAD);
        auto_mode   = (mode >= TMODE_AUTO);
        any_btn     = dpad_up | dpad_down;
    end

    // Source arbitration, D-pad ramp and handoff slew.
    always_comb begin
        state_d  = state_q;
        thrust_d = thrust_q;
        acc_d    = acc_q;
        hclr     = 1'b0;
        unique case (state_q)
            ANALOG: begin
                if (force_dpad || (auto_mode && any_btn)) begin
                    state_d = DPAD;
                    acc_d   = thrust_q;
                end else begin
                    thrust_d = ana;
                end
            end
            DPAD: begin
                if (rtick) begin
                    if (dpad_up && !dpad_down && (acc_q < MAX_T)) begin
                        acc_d = acc_q + 8'd1;
                    end else if (dpad_down && !dpad_up && (acc_q != 8'd0)) begin
                        acc_d = acc_q - 8'd1;
                    end
                end
                thrust_d = acc_d;
                if (force_ana || (auto_mode && stick_claim && !any_btn)) begin
                    state_d = HANDOFF;
                    hclr    = 1'b1;
                end
            end
            HANDOFF: begin
                if (force_dpad || (auto_mode && any_btn)) begin
                    state_d = DPAD;
                    acc_d   = thrust_q;
                end else if (thrust_q == ana) begin
                    state_d = ANALOG;
                end else if (htick) begin
                    thrust_d = (thrust_q < ana) ? (thrust_q + 8'd1) : (thrust_q - 8'd1);
                end
            end
            default: begin
                state_d = DPAD;
            end
        endcase
    end

    // State, lever value, accumulator and registered status flags.
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= DPAD;
            thrust_q   <= 8'd0;
            acc_q      <= 8'd0;
            src_dpad_q <= 1'b1;
            handoff_q  <= 1'b0;
            at_limit_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            thrust_q   <= thrust_d;
            acc_q      <= acc_d;
            src_dpad_q <= (state_d == DPAD);
            handoff_q  <= (state_d == HANDOFF);
            at_limit_q <= (thrust_d == 8'd0) || (thrust_d == MAX_T);
        end
    end

    assign thrust   = thrust_q;
    assign src_dpad = src_dpad_q;
    assign handoff  = handoff_q;
    assign at_limit = at_limit_q;

endmodule

// File: tb/tb_thrust_input_ctrl.sv
// Self-checking bench for thrust_input_ctrl: directed test-plan scenarios plus
// randomized segments, every cycle compared against a behavioural model.
module tb_thrust_input_ctrl;

   localparam int TD   = 8;
   localparam int HD   = 4;
   localparam int DZ   = 16;
   localparam int MAXT = 254;

   localparam int SRC_ANALOG = 0;
   localparam int SRC_DPAD   = 1;
   localparam int SRC_SLEW   = 2;

   logic              clk_50 = 1'b0;
   logic              RESET_L;
   logic [1:0]        mode;
   logic signed [7:0] analogY;
   logic              dpadUp;
   logic              dpadDown;
   logic [7:0]        thrust;
   logic              srcDpad;
   logic              handoff;
   logic              atLimit;

   int checks = 0;
   int errors = 0;

   int mSrc;
   int mThrust;
   int mAcc;
   int rampCycle;
   int slewCycle;

   always #5 clk_50 = ~clk_50;

   thrust_input_ctrl #(
      .TICK_DIV    (TD),
      .HANDOFF_DIV (HD),
      .DEADZONE    (DZ),
      .MAX_THRUST  (MAXT)
   ) dut (
      .clk_50    (clk_50),
      .RESET_L   (RESET_L),
      .mode      (mode),
      .analog_y  (analogY),
      .dpad_up   (dpadUp),
      .dpad_down (dpadDown),
      .thrust    (thrust),
      .src_dpad  (srcDpad),
      .handoff   (handoff),
      .at_limit  (atLimit)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int m, input int y, input bit up, input bit down);
      mode     = 2'(m);
      analogY  = 8'(y);
      dpadUp   = up;
      dpadDown = down;
   endtask

   task automatic modelReset();
      mSrc      = SRC_DPAD;
      mThrust   = 0;
      mAcc      = 0;
      rampCycle = 0;
      slewCycle = 0;
   endtask

   // One clock edge of the lever controller described in plain rules.
   task automatic modelStep();
      int  y, target, mag, nSrc, nThrust, nAcc;
      bit  autoSel, pressed, rampStep, slewStep, entering;
      y        = int'(analogY);
      target   = 127 - y;
      if (target > MAXT) target = MAXT;
      mag      = (y < 0) ? -y : y;
      autoSel  = (mode >= 2);
      pressed  = dpadUp || dpadDown;
      rampStep = ((rampCycle % TD) == TD - 1);
      slewStep = ((slewCycle % HD) == HD - 1);
      nSrc     = mSrc;
      nThrust  = mThrust;
      nAcc     = mAcc;
      entering = 1'b0;
      if (mSrc == SRC_ANALOG) begin
         if (mode == 1 || (autoSel && pressed)) begin
            nSrc = SRC_DPAD;
            nAcc = mThrust;
         end else begin
            nThrust = target;
         end
      end else if (mSrc == SRC_DPAD) begin
         if (rampStep && dpadUp && !dpadDown) nAcc = (mAcc + 1 > MAXT) ? MAXT : mAcc + 1;
         if (rampStep && dpadDown && !dpadUp) nAcc = (mAcc - 1 < 0) ? 0 : mAcc - 1;
         nThrust = nAcc;
         if (mode == 0 || (autoSel && mag > DZ && !pressed)) begin
            nSrc     = SRC_SLEW;
            entering = 1'b1;
         end
      end else begin
         if (mode == 1 || (autoSel && pressed)) begin
            nSrc = SRC_DPAD;
            nAcc = mThrust;
         end else if (mThrust == target) begin
            nSrc = SRC_ANALOG;
         end else if (slewStep) begin
            nThrust = (mThrust < target) ? mThrust + 1 : mThrust - 1;
         end
      end
      mSrc      = nSrc;
      mThrust   = nThrust;
      mAcc      = nAcc;
      rampCycle = rampCycle + 1;
      slewCycle = entering ? 0 : slewCycle + 1;
   endtask

   task automatic compareAll();
      checkOutput("cycle.thrust", thrust, mThrust);
      checkOutput("cycle.src_dpad", srcDpad, (mSrc == SRC_DPAD) ? 1 : 0);
      checkOutput("cycle.handoff", handoff, (mSrc == SRC_SLEW) ? 1 : 0);
      checkOutput("cycle.at_limit", atLimit, (mThrust == 0 || mThrust == MAXT) ? 1 : 0);
   endtask

   task automatic stepCycle();
      @(posedge clk_50);
      modelStep();
      #1;
      compareAll();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic waitHandoffDone(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         stepCycle();
         if (!handoff) break;
      end
      checkOutput(tag, handoff, 0);
   endtask

   task automatic waitThrust(input string tag, input int value, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (thrust == 8'(value)) break;
         stepCycle();
      end
      checkOutput(tag, thrust, value);
   endtask

   // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
   task automatic applyReset();
      @(negedge clk_50);
      RESET_L = 1'b0;
      #1;
      checkOutput("reset.thrust", thrust, 0);
      checkOutput("reset.src_dpad", srcDpad, 1);
      checkOutput("reset.handoff", handoff, 0);
      checkOutput("reset.at_limit", atLimit, 1);
      modelReset();
      @(negedge clk_50);
      RESET_L = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int segMode, segY;
      bit segUp, segDown;
      RESET_L = 1'b0;
      applyStimulus(0, 0, 1'b0, 1'b0);
      modelReset();
      repeat (2) @(negedge clk_50);
      checkOutput("init.thrust", thrust, 0);
      checkOutput("init.src_dpad", srcDpad, 1);
      checkOutput("init.handoff", handoff, 0);
      checkOutput("init.at_limit", atLimit, 1);
      RESET_L = 1'b1;

      // Forced analog power-up slew to 127, then clamp at full push.
      stepCycle();
      checkOutput("powerUp.handoff", handoff, 1);
      waitHandoffDone("powerUp.done", 140 * HD);
      checkOutput("forcedAnalog.thrust", thrust, 127);
      checkOutput("forcedAnalog.src_dpad", srcDpad, 0);
      applyStimulus(0, -128, 1'b0, 1'b0);
      stepCycle();
      checkOutput("clamp.thrust", thrust, 254);
      checkOutput("clamp.at_limit", atLimit, 1);

      // D-pad ramp: up to saturation, both held, down to zero.
      applyStimulus(0, 127, 1'b0, 1'b0);
      stepCycle();
      checkOutput("zeroAnalog.thrust", thrust, 0);
      applyStimulus(1, 127, 1'b1, 1'b0);
      stepCycle();
      checkOutput("enterDpad.src_dpad", srcDpad, 1);
      runCycles(100 * TD);
      checkOutput("rampMid.thrust", thrust, 100);
      runCycles(200 * TD);
      checkOutput("rampSat.thrust", thrust, 254);
      checkOutput("rampSat.at_limit", atLimit, 1);
      applyStimulus(1, 127, 1'b1, 1'b1);
      runCycles(20 * TD);
      checkOutput("bothHold.thrust", thrust, 254);
      applyStimulus(1, 127, 1'b0, 1'b1);
      runCycles(260 * TD);
      checkOutput("rampDown.thrust", thrust, 0);
      checkOutput("rampDown.at_limit", atLimit, 1);

      // Auto: analog at 177, D-pad press takes over without a step.
      applyStimulus(0, -50, 1'b0, 1'b0);
      waitHandoffDone("to177.done", 190 * HD);
      checkOutput("to177.thrust", thrust, 177);
      applyStimulus(2, -50, 1'b0, 1'b0);
      runCycles(5);
      checkOutput("autoAnalog.src_dpad", srcDpad, 0);
      applyStimulus(2, -50, 1'b1, 1'b0);
      stepCycle();
      checkOutput("autoPress.src_dpad", srcDpad, 1);
      checkOutput("autoPress.thrust", thrust, 177);
      for (int i = 0; i < TD + 2; i++) begin
         if (thrust != 8'd177) break;
         stepCycle();
      end
      checkOutput("autoFirstStep.thrust", thrust, 178);

      // Auto D-pad to analog from 40 down to 27.
      applyStimulus(2, -50, 1'b0, 1'b1);
      waitThrust("down40.thrust", 40, 140 * TD + TD);
      applyStimulus(2, 100, 1'b0, 1'b0);
      stepCycle();
      checkOutput("claim.handoff", handoff, 1);
      waitHandoffDone("to27.done", 20 * HD);
      checkOutput("to27.thrust", thrust, 27);
      checkOutput("to27.src_dpad", srcDpad, 0);

      // Deadzone boundary: 10 and -16 hold D-pad, -17 claims.
      applyStimulus(2, 100, 1'b1, 1'b0);
      stepCycle();
      checkOutput("reclaim.src_dpad", srcDpad, 1);
      applyStimulus(2, 10, 1'b0, 1'b0);
      runCycles(30);
      checkOutput("deadzone10.src_dpad", srcDpad, 1);
      applyStimulus(2, -16, 1'b0, 1'b0);
      runCycles(5);
      checkOutput("deadzone16.src_dpad", srcDpad, 1);
      applyStimulus(2, -17, 1'b0, 1'b0);
      stepCycle();
      checkOutput("deadzone17.handoff", handoff, 1);
      waitHandoffDone("to144.done", 150 * HD);
      checkOutput("to144.thrust", thrust, 144);

      // Mode 3 acts as auto.
      applyStimulus(3, -17, 1'b0, 1'b1);
      stepCycle();
      checkOutput("mode3Press.src_dpad", srcDpad, 1);
      checkOutput("mode3Press.thrust", thrust, 144);
      applyStimulus(3, 100, 1'b0, 1'b0);
      stepCycle();
      checkOutput("mode3Claim.handoff", handoff, 1);
      waitHandoffDone("mode3To27.done", 140 * HD);
      checkOutput("mode3To27.thrust", thrust, 27);

      // Interrupted handoff: reset at 90, then a D-pad press at 90.
      applyStimulus(0, 0, 1'b0, 1'b0);
      applyReset();
      waitThrust("slew90.thrust", 90, 100 * HD);
      checkOutput("slew90.handoff", handoff, 1);
      applyReset();
      waitThrust("slew90b.thrust", 90, 100 * HD);
      applyStimulus(2, 0, 1'b1, 1'b0);
      stepCycle();
      checkOutput("pressDuringSlew.src_dpad", srcDpad, 1);
      checkOutput("pressDuringSlew.thrust", thrust, 90);
      applyStimulus(1, 0, 1'b0, 1'b0);
      runCycles(3 * TD);
      checkOutput("accHeld.thrust", thrust, 90);

      // Randomized segments with occasional resets.
      for (int seg = 0; seg < 60; seg++) begin
         segMode = int'($urandom_range(0, 3));
         segY    = int'($urandom_range(0, 255)) - 128;
         segUp   = ($urandom_range(0, 2) == 0);
         segDown = ($urandom_range(0, 2) == 0);
         applyStimulus(segMode, segY, segUp, segDown);
         runCycles(int'($urandom_range(1, 80)));
         if ((seg % 17) == 16) applyReset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/thrust_input_ctrl.md
# thrust_input_ctrl

Thrust-lever source controller for the Lunar Lander core, sitting between the MiSTer joystick inputs and `LLANDER_TOP.THRUST`. It arbitrates between the analog stick and a D-pad-driven ramp accumulator as the thrust source. It sequences a rate-limited handoff when the source changes so the lever value never jumps. It clamps the result to the 0..254 range the game's DAC expects.

## Interface
Parameters:
- `TICK_DIV`, 196850: clk_50 cycles per D-pad ramp step (0 to 254 in about 1 s).
- `HANDOFF_DIV`, 19685: clk_50 cycles per slew step during a handoff.
- `DEADZONE`, 16: analog magnitude (signed units) above which auto mode claims the stick.
- `MAX_THRUST`, 254: upper clamp on every path.

Ports (one clock; reset is asynchronous and active-low):
- `clk_50` in 1: system clock, 50 MHz.
- `RESET_L` in 1: asynchronous, active-low reset.
- `mode` in 2: 0 = analog only, 1 = D-pad only, 2 = auto, 3 = treated as 2.
- `analog_y` in 8: signed stick Y; -128 is full push.
- `dpad_up` in 1: raise thrust.
- `dpad_down` in 1: lower thrust.
- `thrust` out 8: registered lever value to the core.
- `src_dpad` out 1: 1 when the D-pad accumulator drives `thrust`.
- `handoff` out 1: 1 while slewing between sources.
- `at_limit` out 1: `thrust` is 0 or `MAX_THRUST`.

## Operation
- **Analog target:** `ana = 127 - analog_y`, computed 9-bit signed, result 0..255, then clamped to `MAX_THRUST`.
- **Ramp prescaler:**
  - Counts 0..`TICK_DIV-1`, free-running.
  - `rtick` pulses on the cycle the count equals `TICK_DIV-1`; the count wraps to 0.
- **Handoff prescaler:** same behaviour with `HANDOFF_DIV`, pulse named `htick`. It is cleared to 0 on entry to HANDOFF.
- **D-pad accumulator `acc`** (8-bit), updated on `rtick` in DPAD:
  - up only: +1, saturating at `MAX_THRUST`.
  - down only: -1, saturating at 0.
  - both or neither: hold.
- **FSM states:** ANALOG, DPAD, HANDOFF.
  - **ANALOG:** `thrust <= ana` every cycle. Go to DPAD when `mode==1`, or when in auto and `dpad_up|dpad_down`. On that transition load `acc <= thrust`, so there is no step.
  - **DPAD:** `thrust <= acc`. Go to HANDOFF when `mode==0`, or when in auto and `|analog_y| > DEADZONE` with no D-pad button held.
  - **HANDOFF:**
    - On each `htick`, `thrust` moves 1 toward `ana`.
    - The state goes to ANALOG on the cycle `thrust == ana`. The equality check is evaluated every cycle, not only on `htick`.
    - If `mode==1`, or auto with a D-pad button pressed, go to DPAD immediately with `acc <= thrust`.
- **Priority:** a mode-forced transition beats an auto transition. In DPAD, a D-pad press beats the analog claim.
- **Status outputs:**
  - `src_dpad = (state==DPAD)`.
  - `handoff = (state==HANDOFF)`.
  - `at_limit` is registered from the next value of `thrust`.

## Timing
- **Reset values:**
  - state DPAD
  - `thrust = 0`, `acc = 0`
  - both prescalers 0
  - `src_dpad = 1`, `handoff = 0`, `at_limit = 1`
- **First cycle after reset:** if `mode==0`, the FSM enters HANDOFF and `thrust` slews up from 0. This gives a deterministic power-up with no lever jump.
- **Latency:**
  - ANALOG: `analog_y` to `thrust` is 1 cycle.
  - DPAD: `rtick` to `thrust` is 1 cycle. `acc` and `thrust` update on the same edge.
  - Mode and button changes are sampled every cycle and take effect on the next edge.
- **Prescalers:** the ramp prescaler is never cleared outside reset, so the first ramp step after entering DPAD arrives within `TICK_DIV` cycles.
- **Reset mid-handoff:** all state returns to its reset values asynchronously. No partial slew is retained.

## Structure
- **Package `llander_pkg`:**
  - `thrust_state_t` enum {ANALOG, DPAD, HANDOFF}
  - localparam `THRUST_MAX = 8'd254`
  - mode encodings `TMODE_ANALOG`, `TMODE_DPAD`, `TMODE_AUTO`
- **Sub-module `tick_prescaler`:**
  - Parameter `DIV`; inputs `clk_50`, `RESET_L`, `clr`; output `tick`.
  - Instantiated twice, once for `rtick` and once for `htick`.

## Test plan
- **Forced analog:** reset with `mode=0`, `analog_y=0`; after 127 `htick`s, `thrust=127`, `handoff=0`, `src_dpad=0`. Then drive `analog_y=-128`; one cycle later `thrust=254` (clamped), `at_limit=1`.
- **D-pad ramp and saturation:**
  - `mode=1`, hold `dpad_up` for 300 `rtick`s: `thrust` rises by 1 per tick, saturates at 254, `at_limit=1`.
  - Hold both buttons: value holds.
  - Hold `dpad_down` for 260 ticks: `thrust=0`.
- **Auto analog to D-pad:** `mode=2`, `analog_y=-50` (`thrust=177`), then press `dpad_up`. The next cycle gives `src_dpad=1`, `thrust=177`, and the next `rtick` gives 178.
- **Auto D-pad to analog:** from DPAD with `thrust=40`, release buttons and set `analog_y=100` (`ana=27`). Expect HANDOFF, 13 `htick` steps down to 27, then ANALOG. With `analog_y=10` (inside the deadzone) the FSM stays in DPAD.
- **Interrupted handoff:** during HANDOFF at `thrust=90`, pulse `RESET_L` low. Expect `thrust=0` and state DPAD asynchronously. Separately, a D-pad press during HANDOFF returns to DPAD with `acc=90`.
- **Mode 3:** behaves identically to mode 2 across the auto scenarios above.
